div_tag_align: RTL and testbench

- Downstream companion of the 32-bit by 16-bit pipelined divider stage in the GMM subtract path.
- The divider carries no sideband through its pipeline. This block queues each operand's sideband tag and zero-denominator flag when the divider accepts the operand.
- It pops the queued entry when the matching quotient emerges, then saturates the quotient to OUT_W bits.
- It emits quotient and tag together on a registered valid/ready output, and drives the divider's src_ready.

---
 rtl/div_tag_align.sv | 120 ++++++++++++
 tb/tb_div_tag_align.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_tag_align.sv
// rtl/div_tag_align.sv - realigns divider quotients with their queued sideband tag and saturates them
// Tags are pushed when the divider accepts an operand and popped in order as quotients emerge.
module div_tag_align #(
    parameter int TAG_W = 24,
    parameter int OUT_W = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    input  logic                     op_ready,
    input  logic [TAG_W-1:0]         op_tag,
    input  logic                     op_denom_zero,
    input  logic                     q_valid,
    input  logic [31:0]              q_data,
    output logic                     q_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_sat,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TAG_W:0]     r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [LW-1:0]      r_level;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_sat;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [TAG_W:0]     w_head;
    logic               w_sat;

    assign q_ready   = ~r_out_valid | out_ready;
    assign w_push    = op_valid & op_ready;
    assign w_pop     = q_valid & q_ready;
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_pop_ok  = w_pop & ~w_empty;

    // Head is read through the registered read pointer, so an entry written last cycle is already visible.
    assign w_head = w_pop_ok ? r_mem[r_rptr] : '0;
    assign w_sat  = w_head[TAG_W] | (|q_data[31:OUT_W]);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= {op_denom_zero, op_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_level <= r_level - 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_tag   <= w_head[TAG_W-1:0];
            r_out_sat   <= w_sat;
            r_out_data  <= w_sat ? '1 : q_data[OUT_W-1:0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_tag       = r_out_tag;
    assign out_sat       = r_out_sat;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;
    assign fifo_level    = r_level;

endmodule

// File: tb/tb_div_tag_align.sv
// tb/tb_div_tag_align.sv - directed bench for div_tag_align with a queue-based reference model
module tb_div_tag_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready = 1'b0;
    logic [23:0] op_tag = '0;
    logic        op_denom_zero = 1'b0;
    logic        q_valid = 1'b0;
    logic [31:0] q_data = '0;
    logic        q_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [23:0] out_tag;
    logic        out_sat;
    logic        err_overflow;
    logic        err_underflow;
    logic [6:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    logic [24:0] mq [$];
    logic [24:0] m_e;
    logic        m_ov = 1'b0;
    logic [15:0] m_data = '0;
    logic [23:0] m_tag = '0;
    logic        m_sat = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    logic [15:0] got_d [$];
    logic [23:0] got_t [$];
    logic        got_s [$];

    int base;
    int idx;
    int n;

    div_tag_align #(.TAG_W(24), .OUT_W(16), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_tag(op_tag), .op_denom_zero(op_denom_zero),
        .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_sat(out_sat), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model, then step the model with the inputs the DUT samples next edge.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_ov = 0; m_data = '0; m_tag = '0; m_sat = 0; m_ovf = 0; m_unf = 0;
        end else begin
            chk("q_ready", q_ready, !m_ov || out_ready);
            chk("out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("out_data", out_data, m_data);
                chk("out_tag", out_tag, m_tag);
                chk("out_sat", out_sat, m_sat);
            end
            chk("fifo_level", fifo_level, mq.size());
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_underflow", err_underflow, m_unf);
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_t.push_back(out_tag);
                got_s.push_back(out_sat);
            end
            if (q_valid && (!m_ov || out_ready)) begin
                if (mq.size() > 0) begin
                    m_e = mq.pop_front();
                end else begin
                    m_e = '0;
                    m_unf = 1;
                end
                m_sat  = m_e[24] || (q_data[31:16] != 16'h0);
                m_data = m_sat ? 16'hFFFF : q_data[15:0];
                m_tag  = m_e[23:0];
                m_ov   = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (op_valid && op_ready) begin
                if (mq.size() < 64) mq.push_back({op_denom_zero, op_tag});
                else m_ovf = 1;
            end
        end
    end

    task automatic push(input logic [23:0] tag, input logic zf);
        op_valid = 1; op_ready = 1; op_tag = tag; op_denom_zero = zf;
        @(posedge clk); #1;
        op_valid = 0; op_ready = 0; op_denom_zero = 0;
    endtask

    task automatic quot(input logic [31:0] d);
        int k = 0;
        logic hs = 0;
        q_valid = 1; q_data = d;
        do begin
            @(negedge clk); hs = q_ready;
            @(posedge clk); #1;
            k++;
        end while (!hs && k < 100);
        chk("quot_handshake", hs, 1);
        q_valid = 0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_q_ready", q_ready, 1);
        chk("rst_errs", {err_overflow, err_underflow}, 0);

        // 1: in-order pairing at divider-like spacing
        base = got_d.size();
        for (int i = 1; i <= 5; i++) push(24'(i), 0);
        for (int i = 1; i <= 5; i++) begin
            quot(32'(i * 10));
            repeat (31) @(posedge clk);
            #1;
        end
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("t1_data", got_d[base+i], 32'((i + 1) * 10));
            chk("t1_tag", got_t[base+i], 32'(i + 1));
            chk("t1_sat", got_s[base+i], 0);
        end
        chk("t1_level", fifo_level, 0);
        chk("t1_errs", {err_overflow, err_underflow}, 0);

        // 2: zero denominator forces saturation
        base = got_d.size();
        push(24'hABCDEF, 1);
        quot(32'h7);
        settle();
        chk("t2_data", got_d[base], 16'hFFFF);
        chk("t2_tag", got_t[base], 24'hABCDEF);
        chk("t2_sat", got_s[base], 1);

        // 3: saturation boundary
        base = got_d.size();
        push(24'h000031, 0);
        push(24'h000032, 0);
        quot(32'h0001_0000);
        quot(32'h0000_FFFF);
        settle();
        chk("t3a_data", got_d[base], 16'hFFFF);
        chk("t3a_sat", got_s[base], 1);
        chk("t3b_data", got_d[base+1], 16'hFFFF);
        chk("t3b_sat", got_s[base+1], 0);
        chk("t3b_tag", got_t[base+1], 24'h000032);

        // 4: backpressure then release
        base = got_d.size();
        for (int i = 0; i < 8; i++) push(24'(32'h40 + i), 0);
        out_ready = 0; idx = 0;
        for (int c = 0; c < 10; c++) begin
            q_valid = 1; q_data = 32'(100 + idx);
            @(negedge clk); if (q_ready) idx++;
            @(posedge clk); #1;
        end
        chk("t4_hold_q_ready", q_ready, 0);
        chk("t4_hold_count", idx, 1);
        out_ready = 1; n = 0;
        while (idx < 8 && n < 50) begin
            q_data = 32'(100 + idx);
            @(negedge clk); if (q_ready) idx++;
            @(posedge clk); #1;
            n++;
        end
        q_valid = 0;
        chk("t4_drain_count", idx, 8);
        settle();
        chk("t4_got", got_d.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t4_data", got_d[base+i], 32'(100 + i));
            chk("t4_tag", got_t[base+i], 32'h40 + i);
        end

        // 5: overflow, full drain, underflow
        base = got_d.size();
        for (int i = 0; i < 65; i++) push(24'(32'h500 + i), 0);
        settle();
        chk("t5_level_full", fifo_level, 64);
        chk("t5_overflow", err_overflow, 1);
        for (int i = 0; i < 64; i++) quot(32'(i));
        settle();
        for (int i = 0; i < 64; i++) chk("t5_tag", got_t[base+i], 32'h500 + i);
        chk("t5_level_empty", fifo_level, 0);
        quot(32'h3);
        settle();
        chk("t5_underflow", err_underflow, 1);
        chk("t5_under_tag", out_tag, 0);
        chk("t5_under_data", out_data, 3);

        // 6: async reset mid-operation
        for (int i = 0; i < 21; i++) push(24'(32'h600 + i), 0);
        out_ready = 0;
        quot(32'h1);
        chk("t6_pre_level", fifo_level, 20);
        chk("t6_pre_valid", out_valid, 1);
        rst = 1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_errs", {err_overflow, err_underflow}, 0);
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        base = got_d.size();
        push(24'h000777, 0);
        quot(32'h5);
        settle();
        chk("t6_tag", got_t[base], 24'h000777);
        chk("t6_data", got_d[base], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
